// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// FSM states, owner codes and the D-win saturating step.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  function automatic int unsigned dwin_next(
    input int unsigned cnt,
    input int unsigned max_win,
    input logic        gnt_d,
    input logic        i_pend
  );
    if (gnt_d && i_pend)
      return (cnt >= max_win) ? max_win : cnt + 1;
    return 0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between CPU ports, arbiter and unified memory.
// slave = arbiter view, master = CPU/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  logic              stall;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ready,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ready,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata,
    output stall
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ready,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata,
    input  stall
  );

endinterface

// File: rtl/mem_port_arbiter_latency_counter.sv
// Memory latency down-counter for the arbiter WAIT state.
// o_last flags the cycle in which the count reaches zero.
module latency_counter #(
  parameter int MAX = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_last
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(MAX);
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch (I) and data (D) ports.
// D wins by default; I is guaranteed a grant after MAX_DWIN D wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_DWIN    = 4
) (
  input logic          clock,
  input logic          reset,
  mem_port_arbiter_if.slave bus
);

  localparam int DWW = $clog2(MAX_DWIN + 1);

  arb_state_e        r_state;
  arb_owner_e        r_owner;
  logic [DWW-1:0]    r_dwin;
  logic              r_m_en;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_i_ready;
  logic              r_d_ready;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_dwin_ok;
  logic w_gnt_d;
  logic w_gnt_i;
  logic w_last;

  assign w_dwin_ok = (r_dwin < DWW'(MAX_DWIN));
  assign w_gnt_d   = bus.d_req & (~bus.i_req | w_dwin_ok);
  assign w_gnt_i   = bus.i_req & ~w_gnt_d;

  latency_counter #(
    .MAX (MEM_LATENCY)
  ) u_lat (
    .clock  (clock),
    .reset  (reset),
    .i_load (r_state == S_ISSUE),
    .i_dec  (r_state == S_WAIT),
    .o_last (w_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= OWN_I;
      r_dwin    <= '0;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_d || w_gnt_i) begin
            r_state   <= S_ISSUE;
            r_owner   <= w_gnt_d ? OWN_D : OWN_I;
            r_m_en    <= 1'b1;
            r_m_we    <= w_gnt_d & bus.d_we;
            r_m_addr  <= w_gnt_d ? bus.d_addr : bus.i_addr;
            r_m_wdata <= w_gnt_d ? bus.d_wdata : '0;
            r_dwin    <= DWW'(dwin_next(
                           int'(r_dwin), MAX_DWIN,
                           w_gnt_d, bus.i_req));
          end
        end
        S_ISSUE: begin
          r_m_en  <= 1'b0;
          r_m_we  <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_last) begin
            r_state   <= S_DONE;
            r_i_ready <= (r_owner == OWN_I);
            r_d_ready <= (r_owner == OWN_D);
            r_i_rdata <= (r_owner == OWN_I) ? bus.m_rdata : '0;
            r_d_rdata <= (r_owner == OWN_D) ? bus.m_rdata : '0;
          end
        end
        S_DONE: begin
          // back to IDLE so a held req cannot re-grant during ready
          r_state   <= S_IDLE;
          r_i_ready <= 1'b0;
          r_d_ready <= 1'b0;
          r_i_rdata <= '0;
          r_d_rdata <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_en    = r_m_en;
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.i_ready = r_i_ready;
  assign bus.d_ready = r_d_ready;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
  assign bus.stall   = (bus.i_req & ~r_i_ready)
                     | (bus.d_req & ~r_d_ready);

endmodule
